// File: rtl/spi_ram_master_if.sv
// Host handshake plus SPI pins for spi_ram_master.
// slave = the controller itself; master = the host/board side that drives requests and miso.
interface spi_ram_master_if;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] payload;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       ss_n;
  logic       sclk;
  logic       mosi;
  logic       miso;

  modport master (output start, cmd, payload, miso,
                  input  busy, done, rd_data, ss_n, sclk, mosi);
  modport slave  (input  start, cmd, payload, miso,
                  output busy, done, rd_data, ss_n, sclk, mosi);
endinterface

// File: rtl/spi_ram_master.sv
// SPI mode-0 master issuing 10-bit {cmd,payload} frames to a serial RAM;
// cmd=11 adds a turnaround period and an 8-bit read-back.
module spi_ram_master #(
  parameter int CLK_DIV = 2
) (
  input logic             clk,
  input logic             rst_n,
  spi_ram_master_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SHIFT_OUT, TURN, SHIFT_IN, GAP} state_t;

  state_t     state, state_nxt;
  logic [7:0] div_cnt;
  logic       phase;
  logic [3:0] bit_cnt;
  logic [9:0] sr;
  logic [7:0] rx;
  logic [7:0] rd_q;
  logic       is_rd;
  logic       done_q;
  logic       half_end, period_end, rise_edge, accept;

  assign half_end   = (div_cnt == 8'(CLK_DIV - 1));
  assign period_end = half_end & phase;
  assign rise_edge  = half_end & ~phase;
  assign accept     = (state == IDLE) & bus.start;

  // Every non-idle state, GAP included, is timed in whole SCLK periods,
  // so all transitions happen on a period boundary.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bus.start) state_nxt = SHIFT_OUT;
      SHIFT_OUT: if (period_end && bit_cnt == 4'd9) state_nxt = is_rd ? TURN : GAP;
      TURN:      if (period_end) state_nxt = SHIFT_IN;
      SHIFT_IN:  if (period_end && bit_cnt == 4'd7) state_nxt = GAP;
      GAP:       if (period_end) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
      sr      <= '0;
      rx      <= '0;
      rd_q    <= '0;
      is_rd   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        sr      <= {bus.cmd, bus.payload};
        is_rd   <= (bus.cmd == 2'b11);
        div_cnt <= '0;
        phase   <= 1'b0;
        bit_cnt <= '0;
      end else if (state != IDLE) begin
        div_cnt <= half_end ? 8'd0 : div_cnt + 8'd1;
        if (half_end) phase <= ~phase;
        // miso was set up by the slave on the previous falling edge
        if (rise_edge && state == SHIFT_IN) rx <= {rx[6:0], bus.miso};
        if (period_end) begin
          bit_cnt <= (state_nxt != state) ? 4'd0 : bit_cnt + 4'd1;
          if (state == SHIFT_OUT) sr <= {sr[8:0], 1'b0};
          if (state == GAP) begin
            done_q <= 1'b1;
            if (is_rd) rd_q <= rx;
          end
        end
      end
    end
  end

  assign bus.ss_n    = (state == IDLE) || (state == GAP);
  assign bus.sclk    = phase & ~bus.ss_n;
  assign bus.mosi    = (state == SHIFT_OUT) & sr[9];
  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.rd_data = rd_q;
endmodule

// File: tb/tb_spi_ram_master.sv
// Randomized bench: a wire-level RAM slave on the SPI pins plus a command-level
// RAM reference predicting read-back data, frame timing and pin behaviour.
module tb_spi_ram_master;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_ram_master_if bus();
  spi_ram_master #(.CLK_DIV(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int vectors = 0, miscompares = 0;
  int hi_run = 1000, done_cnt = 0, frames = 0;

  // wire-level slave
  logic [7:0] s_mem [256];
  logic [7:0] s_waddr = '0, s_raddr = '0, s_tx = '0;
  logic [9:0] s_frame = '0, s_last_frame = '0;
  int         s_rises = 0, s_falls = 0, s_last_rises = 0;
  bit         s_active = 0, s_txv = 0, s_last_txv = 0;
  logic       s_psclk = 1'b0;

  // command-level reference
  logic [7:0] ref_mem [256];
  logic [7:0] ref_waddr = '0, ref_raddr = '0, ref_rd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (bus.done === 1'b1) done_cnt++;
    hi_run = (bus.ss_n === 1'b1) ? hi_run + 1 : 0;
    if (bus.ss_n === 1'b1) begin
      if (s_active) begin
        s_last_frame = s_frame;
        s_last_rises = s_rises;
        s_last_txv   = s_txv;
        if (s_rises == 10)
          case (s_frame[9:8])
            2'b00:   s_waddr = s_frame[7:0];
            2'b01:   s_mem[s_waddr] = s_frame[7:0];
            2'b10:   s_raddr = s_frame[7:0];
            default: ;
          endcase
      end
      s_active = 0; s_rises = 0; s_falls = 0; s_txv = 0; s_frame = '0;
      bus.miso = 1'b0;
    end else begin
      s_active = 1;
      if (bus.sclk && !s_psclk) begin
        s_rises++;
        if (s_rises <= 10) s_frame = {s_frame[8:0], bus.mosi};
      end
      if (!bus.sclk && s_psclk) begin
        s_falls++;
        if (s_falls == 10 && s_rises == 10 && s_frame[9:8] == 2'b11) begin
          s_tx  = s_mem[s_raddr];
          s_txv = 1;
        end
        bus.miso = (s_txv && s_falls >= 11 && s_falls <= 18) ? s_tx[3'(18 - s_falls)] : 1'b0;
      end
    end
    s_psclk = bus.sclk;
  endtask

  // Caller must be at a negedge; this negedge is cycle 0 of the frame.
  task automatic run_frame(input logic [1:0] c, input logic [7:0] p, input bit stray);
    int n, exp_done, got, ssn_low, busy_n, bad_sclk, bad_mosi, pulse_k, gap_before, first_low;
    logic pm, ps;
    n          = (c == 2'b11) ? 19 : 10;
    exp_done   = 1 + (n + 1) * 2 * D;
    pulse_k    = stray ? int'($urandom_range(2, exp_done - 2)) : -1;
    gap_before = hi_run;
    got = -1; ssn_low = 0; busy_n = 0; bad_sclk = 0; bad_mosi = 0; first_low = -1;
    pm = bus.mosi; ps = bus.sclk;
    bus.start = 1'b1; bus.cmd = c; bus.payload = p;
    frames++;
    case (c)
      2'b00:   ref_waddr = p;
      2'b01:   ref_mem[ref_waddr] = p;
      2'b10:   ref_raddr = p;
      default: ref_rd = ref_mem[ref_raddr];
    endcase
    for (int k = 1; k <= 400; k++) begin
      tick();
      bus.start   = (k == pulse_k);
      bus.cmd     = 2'($urandom);
      bus.payload = 8'($urandom);
      if (bus.ss_n === 1'b0) begin
        ssn_low++;
        if (first_low < 0) first_low = k;
      end else if (bus.sclk !== 1'b0) bad_sclk++;
      if (bus.busy === 1'b1) busy_n++;
      if (k > 1 && bus.mosi !== pm && !(ps && !bus.sclk)) bad_mosi++;
      if (k > 20 * D && bus.mosi !== 1'b0) bad_mosi++;
      pm = bus.mosi; ps = bus.sclk;
      if (bus.done === 1'b1) begin
        got = k;
        break;
      end
    end
    bus.start = 1'b0;
    check("done_cycle", got, exp_done);
    check("ssn_fall", first_low, 1);
    check("ssn_gap_ok", (gap_before >= 2 * D), 1);
    check("ssn_low_len", ssn_low, n * 2 * D);
    check("busy_len", busy_n, (n + 1) * 2 * D);
    check("sclk_rises", s_last_rises, n);
    check("sclk_idle", bad_sclk, 0);
    check("mosi_timing", bad_mosi, 0);
    check("slave_frame", s_last_frame, {c, p});
    check("tx_valid", s_last_txv, (c == 2'b11));
    check("rd_data", bus.rd_data, ref_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      s_mem[i]   = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    rst_n = 1'b0; bus.start = 1'b0; bus.cmd = '0; bus.payload = '0; bus.miso = 1'b0;
    idle(3);
    check("rst_ss_n", bus.ss_n, 1); check("rst_sclk", bus.sclk, 0);
    check("rst_mosi", bus.mosi, 0); check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0); check("rst_rd_data", bus.rd_data, 0);
    rst_n = 1'b1;
    idle(2);

    run_frame(2'b00, 8'h3C, 0); idle(3);
    // RAM sequence, back-to-back
    run_frame(2'b00, 8'h10, 0);
    run_frame(2'b01, 8'h77, 0);
    run_frame(2'b10, 8'h10, 0);
    run_frame(2'b11, 8'h00, 0);
    check("seq_rd_77", bus.rd_data, 8'h77);
    idle(2);
    run_frame(2'b00, 8'h20, 1); run_frame(2'b01, 8'hA5, 1);
    run_frame(2'b10, 8'h20, 0); run_frame(2'b11, 8'h5A, 1);
    check("read_a5", bus.rd_data, 8'hA5);

    for (int i = 0; i < 30; i++) begin
      logic [1:0] c;
      logic [7:0] p;
      c = 2'($urandom);
      p = 8'($urandom);
      if (c == 2'b00 || c == 2'b10) p = 8'($urandom_range(0, 7)) + 8'h10;
      run_frame(c, p, 1'($urandom));
      if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 5)));
    end

    // reset in the middle of a read
    begin
      int dc;
      bus.start = 1'b1; bus.cmd = 2'b11; bus.payload = 8'h00;
      for (int k = 1; k <= 30; k++) begin
        tick();
        bus.start = 1'b0;
      end
      dc = done_cnt;
      rst_n = 1'b0;
      tick();
      check("mid_rst_ss_n", bus.ss_n, 1); check("mid_rst_sclk", bus.sclk, 0);
      check("mid_rst_busy", bus.busy, 0); check("mid_rst_rd", bus.rd_data, 0);
      check("mid_rst_done", bus.done, 0);
      // start held during reset must not launch a frame
      bus.start = 1'b1; bus.cmd = 2'b01;
      idle(3);
      rst_n = 1'b1; bus.start = 1'b0;
      ref_rd = '0;
      tick();
      check("rst_start_busy", bus.busy, 0);
      idle(100);
      check("mid_rst_no_done", done_cnt - dc, 0);
    end

    run_frame(2'b10, 8'h10, 0);
    run_frame(2'b11, 8'h00, 0);
    idle(5);
    check("done_total", done_cnt, frames);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
